// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one send_serial transmitter between N byte-stream requesters.
// Holds the grant for a whole message; ready is a same-cycle accept, tx_we follows one cycle later.
module uart_tx_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  output logic [7:0]       tx_data,
  output logic             tx_we,
  input  logic             tx_busy,
  output logic [IDW-1:0]   grant_id,
  output logic             locked
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    HOLD,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic           last_q, last_d;
  logic           locked_q, locked_d;
  logic [7:0]     tx_data_q, tx_data_d;

  logic [7:0]     req_byte [N];
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;
  logic           acc_en;
  logic [IDW-1:0] acc_id;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign req_byte[i] = req_data[8*i +: 8];
  end

  // First valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % N);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    last_d    = last_q;
    locked_d  = locked_q;
    tx_data_d = tx_data_q;
    req_ready = '0;
    tx_we     = 1'b0;
    acc_en    = 1'b0;
    acc_id    = '0;

    case (state_q)
      IDLE: begin
        acc_en = win_found;
        acc_id = win_id;
      end
      SEND: begin
        tx_we   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (!tx_busy) begin
          state_d = last_q ? DONE : HOLD;
        end
      end
      HOLD: begin
        // Only the message owner may continue; everyone else waits for DONE.
        acc_en = req_valid[grant_q];
        acc_id = grant_q;
      end
      DONE: begin
        rr_ptr_d = (grant_q == IDW'(N - 1)) ? '0 : grant_q + 1'b1;
        locked_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (acc_en) begin
      req_ready[acc_id] = 1'b1;
      tx_data_d         = req_byte[acc_id];
      grant_d           = acc_id;
      last_d            = req_last[acc_id];
      locked_d          = ~req_last[acc_id];
      state_d           = SEND;
    end

    // No handshake may complete on a reset edge, it would be silently dropped.
    if (!rst) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      last_q    <= 1'b0;
      locked_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      locked_q  <= locked_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a send_serial busy model and per-requester byte queues.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [7:0]  d;
    logic [1:0]  g;
    logic        l;
    logic [31:0] cyc;
  } we_rec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_we;
  logic           tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           locked;

  int checks = 0;
  int failures = 0;
  int busy_len = 2;
  int bcnt = 0;
  int ready_cnt [N];
  logic [8:0] rq0[$], rq1[$], rq2[$], rq3[$];
  we_rec_t we_log[$];
  bit mon_en = 1'b0;
  bit hs, hs_prev = 1'b0;
  logic [7:0] last_we_data = 8'h00;
  logic [31:0] cyc = 0;

  uart_tx_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
    .grant_id(grant_id), .locked(locked)
  );

  always #5 clk = ~clk;

  // send_serial model: busy rises the cycle after we and stays up busy_len cycles.
  always @(posedge clk) begin
    if (!rst) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (tx_we) begin
      tx_busy <= 1'b1;
      bcnt    <= busy_len - 1;
    end else if (tx_busy) begin
      if (bcnt == 0) tx_busy <= 1'b0;
      else bcnt <= bcnt - 1;
    end
  end

  task automatic push_req(input int i, input logic [7:0] d, input logic l);
    case (i)
      0: rq0.push_back({l, d});
      1: rq1.push_back({l, d});
      2: rq2.push_back({l, d});
      default: rq3.push_back({l, d});
    endcase
  endtask

  task automatic pop_req(input int i);
    case (i)
      0: void'(rq0.pop_front());
      1: void'(rq1.pop_front());
      2: void'(rq2.pop_front());
      default: void'(rq3.pop_front());
    endcase
  endtask

  // Requesters present their queue head from the falling edge and hold it until accepted.
  always @(negedge clk) begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    if (rq0.size() > 0) begin req_valid[0] = 1'b1; {req_last[0], req_data[7:0]}   = rq0[0]; end
    if (rq1.size() > 0) begin req_valid[1] = 1'b1; {req_last[1], req_data[15:8]}  = rq1[0]; end
    if (rq2.size() > 0) begin req_valid[2] = 1'b1; {req_last[2], req_data[23:16]} = rq2[0]; end
    if (rq3.size() > 0) begin req_valid[3] = 1'b1; {req_last[3], req_data[31:24]} = rq3[0]; end
  end

  // Monitor samples one time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (mon_en) begin
      cyc++;
      checks++;
      if (tx_we !== hs_prev) begin
        failures++;
        $display("FAIL we_after_accept cyc=%0d tx_we=%b need %b", cyc, tx_we, hs_prev);
      end
      if (tx_we === 1'b1) begin
        checks++;
        if (tx_busy !== 1'b0) begin
          failures++;
          $display("FAIL we_while_busy cyc=%0d tx_busy=%b need 0", cyc, tx_busy);
        end
        we_log.push_back('{d: tx_data, g: grant_id, l: locked, cyc: cyc});
        last_we_data = tx_data;
      end
      if (tx_busy === 1'b1) begin
        checks++;
        if (tx_data !== last_we_data) begin
          failures++;
          $display("FAIL data_stable cyc=%0d tx_data=%h need %h", cyc, tx_data, last_we_data);
        end
      end
      checks++;
      if ((req_ready & ~req_valid) !== '0 || $countones(req_ready) > 1) begin
        failures++;
        $display("FAIL ready_onehot cyc=%0d req_ready=%b req_valid=%b", cyc, req_ready, req_valid);
      end
      hs = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (rst && req_valid[i] && req_ready[i]) begin
          hs = 1'b1;
          ready_cnt[i]++;
          pop_req(i);
        end
      end
      hs_prev = hs;
    end
  end

  task automatic wait_we(input int n, input string name);
    int budget = 400;
    while (we_log.size() < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    checks++;
    if (we_log.size() < n) begin
      failures++;
      $display("FAIL %s_timeout got %0d we pulses, need %0d", name, we_log.size(), n);
    end
  endtask

  task automatic drain(input string name);
    int budget = 600;
    while ((rq0.size() + rq1.size() + rq2.size() + rq3.size()) > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if ((rq0.size() + rq1.size() + rq2.size() + rq3.size()) != 0) begin
      failures++;
      $display("FAIL %s_drain bytes left=%0d need 0", name, rq0.size() + rq1.size() + rq2.size() + rq3.size());
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (tx_we !== 1'b0)   begin failures++; $display("FAIL reset_we got %b need 0", tx_we); end
    if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got %b need 0", req_ready); end
    if (locked !== 1'b0)  begin failures++; $display("FAIL reset_locked got %b need 0", locked); end
    if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got %0d need 0", grant_id); end
    if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got %h need 00", tx_data); end
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single_byte();
    we_log.delete();
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    @(posedge clk); #1;
    push_req(1, 8'h41, 1'b1);
    wait_we(1, "single");
    repeat (15) @(posedge clk);
    #1;
    checks += 3;
    if (we_log.size() != 1) begin failures++; $display("FAIL single_we_count got %0d need 1", we_log.size()); end
    if (ready_cnt[1] != 1)  begin failures++; $display("FAIL single_ready_count got %0d need 1", ready_cnt[1]); end
    if (we_log.size() > 0 && {we_log[0].d, we_log[0].g, we_log[0].l} !== {8'h41, 2'd1, 1'b0}) begin
      failures++;
      $display("FAIL single_byte got d=%h g=%0d l=%b need d=41 g=1 l=0", we_log[0].d, we_log[0].g, we_log[0].l);
    end
    // rr_ptr is now 2, so requester 2 beats requester 0.
    push_req(0, 8'h50, 1'b1);
    push_req(2, 8'h52, 1'b1);
    wait_we(3, "single_rr");
    checks += 2;
    if (we_log.size() > 1 && {we_log[1].d, we_log[1].g} !== {8'h52, 2'd2}) begin
      failures++;
      $display("FAIL rr_after_single got d=%h g=%0d need d=52 g=2", we_log[1].d, we_log[1].g);
    end
    if (we_log.size() > 2 && {we_log[2].d, we_log[2].g} !== {8'h50, 2'd0}) begin
      failures++;
      $display("FAIL rr_second got d=%h g=%0d need d=50 g=0", we_log[2].d, we_log[2].g);
    end
    drain("single");
  endtask

  task automatic test_fairness();
    we_log.delete();
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_req(i, 8'h30 + 8'(i), 1'b1);
    wait_we(8, "fair");
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= we_log.size() || we_log[k].d !== 8'h30 + 8'(k % 4) || we_log[k].g !== 2'(k % 4)) begin
        failures++;
        $display("FAIL fair_order%0d got d=%h g=%0d need d=%h g=%0d", k,
                 (k < we_log.size()) ? we_log[k].d : 8'hxx, (k < we_log.size()) ? we_log[k].g : 2'bxx,
                 8'h30 + 8'(k % 4), k % 4);
      end
    end
    drain("fair");
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ready_cnt[i] != 2) begin failures++; $display("FAIL fair_ready%0d got %0d need 2", i, ready_cnt[i]); end
    end
  endtask

  task automatic test_message_lock();
    logic [7:0] ed [4] = '{8'h48, 8'h49, 8'h0A, 8'h55};
    logic [1:0] eg [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
    logic       el [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    we_log.delete();
    @(posedge clk); #1;
    push_req(2, 8'h48, 1'b0);
    push_req(2, 8'h49, 1'b0);
    push_req(2, 8'h0A, 1'b1);
    wait_we(1, "lock_first");
    push_req(0, 8'h55, 1'b1);
    wait_we(4, "lock");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= we_log.size()) begin
        failures++;
        $display("FAIL lock_byte%0d missing", k);
      end else if ({we_log[k].d, we_log[k].g, we_log[k].l} !== {ed[k], eg[k], el[k]}) begin
        failures++;
        $display("FAIL lock_byte%0d got d=%h g=%0d l=%b need d=%h g=%0d l=%b", k,
                 we_log[k].d, we_log[k].g, we_log[k].l, ed[k], eg[k], el[k]);
      end
    end
    drain("lock");
  endtask

  task automatic test_busy_hold();
    busy_len = 10;
    we_log.delete();
    @(posedge clk); #1;
    push_req(1, 8'hA1, 1'b0);
    push_req(1, 8'hA2, 1'b0);
    push_req(1, 8'hA3, 1'b1);
    wait_we(3, "busy");
    drain("busy");
    checks++;
    if (we_log.size() != 3) begin failures++; $display("FAIL busy_we_count got %0d need 3", we_log.size()); end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (k < we_log.size() && (we_log[k].cyc - we_log[k-1].cyc) != 32'd13) begin
        failures++;
        $display("FAIL busy_spacing%0d got %0d need 13", k, we_log[k].cyc - we_log[k-1].cyc);
      end
    end
    busy_len = 2;
  endtask

  task automatic test_starvation();
    int rc1;
    we_log.delete();
    @(posedge clk); #1;
    push_req(3, 8'h70, 1'b0);
    wait_we(1, "starve_first");
    repeat (10) @(posedge clk);
    #1;
    push_req(1, 8'h71, 1'b1);
    rc1 = ready_cnt[1];
    repeat (20) @(posedge clk);
    #1;
    checks += 4;
    if (ready_cnt[1] != rc1) begin failures++; $display("FAIL starve_ready1 got %0d pulses need 0", ready_cnt[1] - rc1); end
    if (locked !== 1'b1)     begin failures++; $display("FAIL starve_locked got %b need 1", locked); end
    if (grant_id !== 2'd3)   begin failures++; $display("FAIL starve_grant got %0d need 3", grant_id); end
    if (we_log.size() != 1)  begin failures++; $display("FAIL starve_we_count got %0d need 1", we_log.size()); end
    push_req(3, 8'h73, 1'b1);
    push_req(0, 8'h60, 1'b1);
    wait_we(4, "starve");
    checks += 3;
    if (we_log.size() > 1 && {we_log[1].d, we_log[1].g, we_log[1].l} !== {8'h73, 2'd3, 1'b0}) begin
      failures++;
      $display("FAIL starve_resume got d=%h g=%0d l=%b need d=73 g=3 l=0", we_log[1].d, we_log[1].g, we_log[1].l);
    end
    if (we_log.size() > 2 && {we_log[2].d, we_log[2].g} !== {8'h60, 2'd0}) begin
      failures++;
      $display("FAIL starve_next got d=%h g=%0d need d=60 g=0", we_log[2].d, we_log[2].g);
    end
    if (we_log.size() > 3 && {we_log[3].d, we_log[3].g} !== {8'h71, 2'd1}) begin
      failures++;
      $display("FAIL starve_last got d=%h g=%0d need d=71 g=1", we_log[3].d, we_log[3].g);
    end
    drain("starve");
  endtask

  task automatic test_reset_mid_wait();
    busy_len = 10;
    we_log.delete();
    @(posedge clk); #1;
    push_req(1, 8'h11, 1'b0);
    wait_we(1, "rstw_first");
    repeat (3) @(posedge clk);
    #1;
    push_req(2, 8'h22, 1'b1);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL rstw_locked_before got %b need 1", locked); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks += 4;
    if (tx_we !== 1'b0)    begin failures++; $display("FAIL rstw_we got %b need 0", tx_we); end
    if (req_ready !== '0)  begin failures++; $display("FAIL rstw_ready got %b need 0", req_ready); end
    if (locked !== 1'b0)   begin failures++; $display("FAIL rstw_locked got %b need 0", locked); end
    if (grant_id !== 2'd0) begin failures++; $display("FAIL rstw_grant got %0d need 0", grant_id); end
    we_log.delete();
    @(negedge clk);
    rst = 1'b1;
    wait_we(1, "rstw");
    checks++;
    if (we_log.size() > 0 && {we_log[0].d, we_log[0].g} !== {8'h22, 2'd2}) begin
      failures++;
      $display("FAIL rstw_regrant got d=%h g=%0d need d=22 g=2", we_log[0].d, we_log[0].g);
    end
    drain("rstw");
    busy_len = 2;
  endtask

  initial begin
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    test_reset();
    test_single_byte();
    pulse_reset();
    test_fairness();
    test_message_lock();
    test_busy_hold();
    test_starvation();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
